mem_port_arbiter: RTL and testbench

- Shares the single synchronous memory port between instruction fetch (read-only) and the execute stage load/store path (read/write).
- Sequences multi-cycle reads, returns data to the correct requester and generates the pipeline stall seen by execute.
- Priority goes to load/store, since it belongs to the older instruction. A starvation guard guarantees fetch progress.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around mem_port_arbiter.
// The master modport is the arbiter's view; slave is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR   = 32,
    parameter int unsigned W_DATA = 32
);
    logic              if_req_i;
    logic [ADDR-1:0]   if_addr_i;
    logic              if_grant_o;
    logic              if_valid_o;
    logic [W_DATA-1:0] if_data_o;

    logic              ls_req_i;
    logic              ls_write_i;
    logic [ADDR-1:0]   ls_addr_i;
    logic [W_DATA-1:0] ls_wdata_i;
    logic              ls_grant_o;
    logic              ls_valid_o;
    logic [W_DATA-1:0] ls_rdata_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR-1:0]   mem_addr_o;
    logic [W_DATA-1:0] mem_wdata_o;
    logic [W_DATA-1:0] mem_rdata_i;

    logic              stall_o;

    modport master (
        input  if_req_i, if_addr_i,
        input  ls_req_i, ls_write_i, ls_addr_i, ls_wdata_i,
        input  mem_rdata_i,
        output if_grant_o, if_valid_o, if_data_o,
        output ls_grant_o, ls_valid_o, ls_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output stall_o
    );

    modport slave (
        output if_req_i, if_addr_i,
        output ls_req_i, ls_write_i, ls_addr_i, ls_wdata_i,
        output mem_rdata_i,
        input  if_grant_o, if_valid_o, if_data_o,
        input  ls_grant_o, ls_valid_o, ls_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  stall_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between fetch (read-only) and load/store.
// Load/store has priority; a starvation counter forces a fetch grant after STARVE_MAX ls wins.
module mem_port_arbiter #(
    parameter int unsigned ADDR       = 32,
    parameter int unsigned W_DATA     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic             clk,
    input logic             reset,
    mem_port_arbiter_if.master bus
);

    localparam int unsigned CntW = $clog2(MEM_LAT + 1);
    localparam int unsigned StW  = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] LatLast   = CntW'(MEM_LAT);
    localparam logic [StW-1:0]  StarveTop = StW'(STARVE_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StIfWait,
        StLsWait
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [StW-1:0]    starve_q, starve_d;

    logic              rd_done;
    logic              eligible;
    logic              if_win;
    logic              ls_win;
    logic              ls_read;
    logic              if_valid;
    logic              ls_valid;
    logic [ADDR-1:0]   addr_sel;
    logic [W_DATA-1:0] wdata_sel;

    // Grants are suppressed while reset is held so every output reads 0 immediately.
    always_comb begin
        rd_done  = (state_q != StIdle) && (cnt_q == LatLast);
        eligible = !reset && ((state_q == StIdle) || rd_done);
        ls_win   = eligible && bus.ls_req_i &&
                   !(bus.if_req_i && (starve_q == StarveTop));
        if_win   = eligible && !ls_win && bus.if_req_i;
        ls_read  = ls_win && !bus.ls_write_i;
        if_valid = (state_q == StIfWait) && rd_done;
        ls_valid = (state_q == StLsWait) && rd_done;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;

        if ((state_q != StIdle) && !rd_done) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (eligible) begin
            if (if_win) begin
                state_d = StIfWait;
                cnt_d   = CntW'(1);
            end else if (ls_read) begin
                state_d = StLsWait;
                cnt_d   = CntW'(1);
            end else begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        end

        if (!bus.if_req_i || if_win) begin
            starve_d = '0;
        end else if (ls_win && (starve_q != StarveTop)) begin
            starve_d = starve_q + StW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        if (if_win) begin
            addr_sel = bus.if_addr_i;
        end else if (ls_win) begin
            addr_sel  = bus.ls_addr_i;
            wdata_sel = bus.ls_wdata_i;
        end
    end

    always_comb begin
        bus.if_grant_o  = if_win;
        bus.ls_grant_o  = ls_win;
        bus.if_valid_o  = if_valid;
        bus.if_data_o   = if_valid ? bus.mem_rdata_i : '0;
        bus.ls_valid_o  = ls_valid;
        bus.ls_rdata_o  = ls_valid ? bus.mem_rdata_i : '0;
        bus.mem_en_o    = if_win || ls_win;
        bus.mem_we_o    = ls_win && bus.ls_write_i;
        bus.mem_addr_o  = addr_sel;
        bus.mem_wdata_o = wdata_sel;
        bus.stall_o     = !reset && ((bus.ls_req_i && !ls_win) ||
                                     ((state_q == StLsWait) && !ls_valid));
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a vector table on a MEM_LAT=1 instance, plus directed corner
// sequences and random traffic on a MEM_LAT=3 instance checked against a cycle-count model.
module tb_mem_port_arbiter;

    localparam int unsigned LatA = 3;
    localparam int unsigned LatB = 1;
    localparam int unsigned SMax = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    mem_port_arbiter_if #(.ADDR(32), .W_DATA(32)) ia ();
    mem_port_arbiter_if #(.ADDR(32), .W_DATA(32)) ib ();

    mem_port_arbiter #(.ADDR(32), .W_DATA(32), .MEM_LAT(LatA), .STARVE_MAX(SMax)) u_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ia)
    );

    mem_port_arbiter #(.ADDR(32), .W_DATA(32), .MEM_LAT(LatB), .STARVE_MAX(SMax)) u_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ib)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    // ---------------- vector table for the MEM_LAT=1 instance ----------------
    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        ls_req;
        logic        ls_write;
        logic [31:0] ls_addr;
        logic [31:0] ls_wdata;
        logic [31:0] rdata;
        logic        x_if_grant;
        logic        x_if_valid;
        logic [31:0] x_if_data;
        logic        x_ls_grant;
        logic        x_ls_valid;
        logic [31:0] x_ls_rdata;
        logic        x_mem_en;
        logic        x_mem_we;
        logic [31:0] x_mem_addr;
        logic [31:0] x_mem_wdata;
        logic        x_stall;
    } vec_t;

    vec_t vb [12];

    // ---------------- stimulus and model state for the MEM_LAT=3 instance ----------------
    logic        a_if_req, a_ls_req, a_ls_write;
    logic [31:0] a_if_addr, a_ls_addr, a_ls_wdata;

    int cyc     = 0;
    int ret_cyc = -1;  // cycle index at which the outstanding read returns, -1 if none
    bit ret_ls  = 1'b0;
    int starve  = 0;
    bit e_gif, e_gls;

    logic        g_if_grant, g_ls_grant, g_ls_valid, g_mem_en, g_mem_we, g_stall;
    logic [31:0] g_mem_wdata;

    task automatic step_a(input bit rst);
        logic [31:0] rdata;
        bit          elig;
        bit          v_if;
        bit          v_ls;
        bit          e_stall;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        @(posedge clk);
        #1;
        rdata          = $urandom;
        rst_a          = rst;
        ia.if_req_i    = a_if_req;
        ia.if_addr_i   = a_if_addr;
        ia.ls_req_i    = a_ls_req;
        ia.ls_write_i  = a_ls_write;
        ia.ls_addr_i   = a_ls_addr;
        ia.ls_wdata_i  = a_ls_wdata;
        ia.mem_rdata_i = rdata;
        @(negedge clk);
        if (rst) begin
            ret_cyc = -1;
            starve  = 0;
        end
        v_if    = !rst && (ret_cyc == cyc) && !ret_ls;
        v_ls    = !rst && (ret_cyc == cyc) && ret_ls;
        elig    = !rst && ((ret_cyc < 0) || (ret_cyc == cyc));
        e_gls   = elig && a_ls_req && !(a_if_req && (starve == SMax));
        e_gif   = elig && !e_gls && a_if_req;
        e_addr  = e_gif ? a_if_addr : (e_gls ? a_ls_addr : 32'h0);
        e_wdata = e_gls ? a_ls_wdata : 32'h0;
        e_stall = !rst && ((a_ls_req && !e_gls) || (ret_ls && (ret_cyc > cyc)));

        check("a.if_grant",  ia.if_grant_o,  e_gif);
        check("a.ls_grant",  ia.ls_grant_o,  e_gls);
        check("a.if_valid",  ia.if_valid_o,  v_if);
        check("a.if_data",   ia.if_data_o,   v_if ? rdata : 32'h0);
        check("a.ls_valid",  ia.ls_valid_o,  v_ls);
        check("a.ls_rdata",  ia.ls_rdata_o,  v_ls ? rdata : 32'h0);
        check("a.mem_en",    ia.mem_en_o,    e_gif || e_gls);
        check("a.mem_we",    ia.mem_we_o,    e_gls && a_ls_write);
        check("a.mem_addr",  ia.mem_addr_o,  e_addr);
        check("a.mem_wdata", ia.mem_wdata_o, e_wdata);
        check("a.stall",     ia.stall_o,     e_stall);

        g_if_grant  = ia.if_grant_o;
        g_ls_grant  = ia.ls_grant_o;
        g_ls_valid  = ia.ls_valid_o;
        g_mem_en    = ia.mem_en_o;
        g_mem_we    = ia.mem_we_o;
        g_mem_wdata = ia.mem_wdata_o;
        g_stall     = ia.stall_o;

        if (ret_cyc == cyc) ret_cyc = -1;
        if (e_gif || (e_gls && !a_ls_write)) begin
            ret_cyc = cyc + int'(LatA);
            ret_ls  = e_gls;
        end
        if (rst || !a_if_req || e_gif) starve = 0;
        else if (e_gls && (starve < SMax)) starve++;
        cyc++;
    endtask

    task automatic idle_a(input int n);
        a_if_req = 1'b0;
        a_ls_req = 1'b0;
        for (int k = 0; k < n; k++) step_a(1'b0);
    endtask

    initial begin
        int          ng;
        int          cnt_v;
        int          cnt_e;
        logic [15:0] pattern;

        rst_a = 1'b1;
        rst_b = 1'b1;
        a_if_req = 1'b0; a_ls_req = 1'b0; a_ls_write = 1'b0;
        a_if_addr = '0; a_ls_addr = '0; a_ls_wdata = '0;
        ia.if_req_i = 1'b0; ia.if_addr_i = '0; ia.ls_req_i = 1'b0; ia.ls_write_i = 1'b0;
        ia.ls_addr_i = '0; ia.ls_wdata_i = '0; ia.mem_rdata_i = '0;
        ib.if_req_i = 1'b0; ib.if_addr_i = '0; ib.ls_req_i = 1'b1; ib.ls_write_i = 1'b0;
        ib.ls_addr_i = 32'h10; ib.ls_wdata_i = '0; ib.mem_rdata_i = 32'h55;

        //              if a         ls w addr      wdata         rdata
        //              gif ifv ifdata gls lsv lsdata en we addr wdata stall
        vb[0]  = '{1, 32'h00, 0, 0, 32'h00, 32'h0,        32'h11,
                   1, 0, 32'h0,  0, 0, 32'h0,  1, 0, 32'h00, 32'h0,        0};
        vb[1]  = '{1, 32'h04, 0, 0, 32'h00, 32'h0,        32'hA1,
                   1, 1, 32'hA1, 0, 0, 32'h0,  1, 0, 32'h04, 32'h0,        0};
        vb[2]  = '{1, 32'h08, 0, 0, 32'h00, 32'h0,        32'hA2,
                   1, 1, 32'hA2, 0, 0, 32'h0,  1, 0, 32'h08, 32'h0,        0};
        vb[3]  = '{0, 32'h00, 0, 0, 32'h00, 32'h0,        32'hA3,
                   0, 1, 32'hA3, 0, 0, 32'h0,  0, 0, 32'h00, 32'h0,        0};
        vb[4]  = '{0, 32'h00, 0, 0, 32'h00, 32'h0,        32'hA4,
                   0, 0, 32'h0,  0, 0, 32'h0,  0, 0, 32'h00, 32'h0,        0};
        vb[5]  = '{1, 32'h80, 1, 1, 32'h40, 32'hDEADBEEF, 32'hA5,
                   0, 0, 32'h0,  1, 0, 32'h0,  1, 1, 32'h40, 32'hDEADBEEF, 0};
        vb[6]  = '{1, 32'h80, 0, 0, 32'h00, 32'h0,        32'hA6,
                   1, 0, 32'h0,  0, 0, 32'h0,  1, 0, 32'h80, 32'h0,        0};
        vb[7]  = '{0, 32'h00, 1, 0, 32'h44, 32'h0,        32'hB0,
                   0, 1, 32'hB0, 1, 0, 32'h0,  1, 0, 32'h44, 32'h0,        0};
        vb[8]  = '{0, 32'h00, 0, 0, 32'h00, 32'h0,        32'hB1,
                   0, 0, 32'h0,  0, 1, 32'hB1, 0, 0, 32'h00, 32'h0,        0};
        vb[9]  = '{0, 32'h00, 1, 0, 32'h48, 32'h0,        32'hB2,
                   0, 0, 32'h0,  1, 0, 32'h0,  1, 0, 32'h48, 32'h0,        0};
        vb[10] = '{0, 32'h00, 1, 0, 32'h4C, 32'h0,        32'hB3,
                   0, 0, 32'h0,  1, 1, 32'hB3, 1, 0, 32'h4C, 32'h0,        0};
        vb[11] = '{0, 32'h00, 0, 0, 32'h00, 32'h0,        32'hB4,
                   0, 0, 32'h0,  0, 1, 32'hB4, 0, 0, 32'h00, 32'h0,        0};

        // A held load request during reset must not leak through.
        @(negedge clk);
        check("b.reset_mem_en", ib.mem_en_o,   1'b0);
        check("b.reset_grant",  ib.ls_grant_o, 1'b0);
        check("b.reset_stall",  ib.stall_o,    1'b0);
        @(posedge clk); #1;
        rst_b = 1'b0;
        ib.ls_req_i = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            ib.if_req_i    = vb[i].if_req;
            ib.if_addr_i   = vb[i].if_addr;
            ib.ls_req_i    = vb[i].ls_req;
            ib.ls_write_i  = vb[i].ls_write;
            ib.ls_addr_i   = vb[i].ls_addr;
            ib.ls_wdata_i  = vb[i].ls_wdata;
            ib.mem_rdata_i = vb[i].rdata;
            @(negedge clk);
            check($sformatf("b[%0d].if_grant", i),  ib.if_grant_o,  vb[i].x_if_grant);
            check($sformatf("b[%0d].if_valid", i),  ib.if_valid_o,  vb[i].x_if_valid);
            check($sformatf("b[%0d].if_data", i),   ib.if_data_o,   vb[i].x_if_data);
            check($sformatf("b[%0d].ls_grant", i),  ib.ls_grant_o,  vb[i].x_ls_grant);
            check($sformatf("b[%0d].ls_valid", i),  ib.ls_valid_o,  vb[i].x_ls_valid);
            check($sformatf("b[%0d].ls_rdata", i),  ib.ls_rdata_o,  vb[i].x_ls_rdata);
            check($sformatf("b[%0d].mem_en", i),    ib.mem_en_o,    vb[i].x_mem_en);
            check($sformatf("b[%0d].mem_we", i),    ib.mem_we_o,    vb[i].x_mem_we);
            check($sformatf("b[%0d].mem_addr", i),  ib.mem_addr_o,  vb[i].x_mem_addr);
            check($sformatf("b[%0d].mem_wdata", i), ib.mem_wdata_o, vb[i].x_mem_wdata);
            check($sformatf("b[%0d].stall", i),     ib.stall_o,     vb[i].x_stall);
        end

        // Instance A: reset with both requests high, then release.
        a_if_req = 1'b1; a_ls_req = 1'b1; a_if_addr = 32'h4; a_ls_addr = 32'h8;
        step_a(1'b1);
        step_a(1'b1);
        idle_a(2);

        // Continuous contention with stores: four ls grants then one fetch, repeating.
        a_ls_req = 1'b1; a_ls_write = 1'b1; a_ls_addr = 32'h10; a_ls_wdata = 32'h1;
        a_if_req = 1'b1; a_if_addr = 32'h20;
        pattern = '0;
        ng = 0;
        for (int k = 0; k < 40 && ng < 10; k++) begin
            step_a(1'b0);
            if (g_if_grant || g_ls_grant) begin
                pattern = {pattern[14:0], g_if_grant};
                ng++;
            end
        end
        check("a.starve_grants",  ng, 10);
        check("a.starve_pattern", pattern, 16'b0000_0000_0010_0001);
        idle_a(4);

        // Load at T with a fetch raised at T+1: fetch waits for the load return at T+3.
        a_ls_req = 1'b1; a_ls_write = 1'b0; a_ls_addr = 32'h100;
        step_a(1'b0);
        check("a.load_grant", g_ls_grant, 1'b1);
        check("a.load_en",    g_mem_en,   1'b1);
        check("a.load_we",    g_mem_we,   1'b0);
        a_ls_req = 1'b0; a_if_req = 1'b1; a_if_addr = 32'h200;
        step_a(1'b0);
        check("a.load_stall_t1", g_stall, 1'b1);
        check("a.load_ifg_t1",   g_if_grant, 1'b0);
        step_a(1'b0);
        check("a.load_stall_t2", g_stall, 1'b1);
        check("a.load_valid_t2", g_ls_valid, 1'b0);
        step_a(1'b0);
        check("a.load_valid_t3", g_ls_valid, 1'b1);
        check("a.load_ifg_t3",   g_if_grant, 1'b1);
        check("a.load_stall_t3", g_stall, 1'b0);
        idle_a(4);

        // Store beside a fetch: store in one cycle, fetch next, never an ls_valid.
        a_ls_req = 1'b1; a_ls_write = 1'b1; a_ls_addr = 32'h40; a_ls_wdata = 32'hDEADBEEF;
        a_if_req = 1'b1; a_if_addr = 32'h300;
        step_a(1'b0);
        check("a.store_grant", g_ls_grant, 1'b1);
        check("a.store_we",    g_mem_we, 1'b1);
        check("a.store_wdata", g_mem_wdata, 32'hDEADBEEF);
        a_ls_req = 1'b0;
        step_a(1'b0);
        check("a.store_if_next", g_if_grant, 1'b1);
        a_if_req = 1'b0;
        cnt_v = 0;
        for (int k = 0; k < 4; k++) begin
            step_a(1'b0);
            if (g_ls_valid) cnt_v++;
        end
        check("a.store_no_valid", cnt_v, 0);

        // Reset one cycle after a load grant discards the read.
        a_ls_req = 1'b1; a_ls_write = 1'b0; a_ls_addr = 32'h180;
        step_a(1'b0);
        a_ls_req = 1'b0;
        step_a(1'b1);
        check("a.rst_mid_en", g_mem_en, 1'b0);
        cnt_v = 0;
        for (int k = 0; k < 4; k++) begin
            step_a(1'b0);
            if (g_ls_valid) cnt_v++;
        end
        check("a.rst_mid_no_valid", cnt_v, 0);
        a_ls_req = 1'b1; a_ls_addr = 32'h1C0;
        step_a(1'b0);
        check("a.rst_mid_regrant", g_ls_grant, 1'b1);
        idle_a(4);

        // A one-cycle fetch pulse while a read is outstanding leaves no trace.
        a_ls_req = 1'b1; a_ls_write = 1'b0; a_ls_addr = 32'h1E0;
        step_a(1'b0);
        a_ls_req = 1'b0; a_if_req = 1'b1; a_if_addr = 32'h500;
        cnt_v = 0;
        cnt_e = 0;
        for (int k = 0; k < 3; k++) begin
            step_a(1'b0);
            a_if_req = 1'b0;
            if (g_if_grant) cnt_v++;
            if (g_mem_en) cnt_e++;
        end
        check("a.pulse_no_grant", cnt_v, 0);
        check("a.pulse_no_access", cnt_e, 0);
        idle_a(4);

        // Random traffic honouring the hold-until-granted rule, with rare drops and resets.
        for (int i = 0; i < 800; i++) begin
            bit r;
            if (a_if_req && !e_gif) begin
                if ($urandom_range(0, 31) == 0) a_if_req = 1'b0;
            end else begin
                a_if_req  = ($urandom_range(0, 9) < 4);
                a_if_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            end
            if (a_ls_req && !e_gls) begin
                if ($urandom_range(0, 31) == 0) a_ls_req = 1'b0;
            end else begin
                a_ls_req   = ($urandom_range(0, 9) < 5);
                a_ls_write = $urandom_range(0, 1) == 1;
                a_ls_addr  = {22'h1, 8'($urandom_range(0, 255)), 2'b00};
                a_ls_wdata = $urandom;
            end
            r = ($urandom_range(0, 199) == 0);
            step_a(r);
            if (r) begin
                e_gif = 1'b0;
                e_gls = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
